// File: rtl/general_purpose_register_pkg.sv
// Shared constants for the 8 x 16-bit general-purpose register file:
// datapath width, register count, index width and the operation mode codes.
package general_purpose_register_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned MODE_W   = 3;

    localparam logic [MODE_W-1:0] MODE_NOP   = 3'b000;
    localparam logic [MODE_W-1:0] MODE_READ  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_CLEAR = 3'b011;
    localparam logic [MODE_W-1:0] MODE_MOVE  = 3'b100;

    // True for the mode codes that update R[dst_addr].
    function automatic logic is_write_mode(input logic [MODE_W-1:0] mode);
        return (mode == MODE_LOAD) || (mode == MODE_CLEAR) || (mode == MODE_MOVE);
    endfunction

endpackage

// File: rtl/general_purpose_register.sv
// Eight-entry, 16-bit register file; R0 doubles as the accumulator.
// One register operation per clock, selected by mode when enable is high.
// Ports:
//   clk, reset      - clock and synchronous active-high reset (clears R0..R7)
//   enable          - qualifies mode; low means no bus operation
//   alu2in_enable   - gates alu_2nd_in
//   acc_enable      - writes acc_input into R0, independent of enable
//   mode            - NOP/READ/LOAD/CLEAR/MOVE
//   src_addr        - source register index (READ, MOVE, ALU operand B)
//   dst_addr        - destination register index (LOAD, CLEAR, MOVE)
//   acc_input       - accumulator write-back value
//   alu_1st_in      - combinational R0
//   alu_2nd_in      - combinational R[src_addr] or 0
//   data            - shared bidirectional data bus
module general_purpose_register
    import general_purpose_register_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   alu2in_enable,
    input  logic                   acc_enable,
    input  logic [MODE_W-1:0]      mode,
    input  logic [ADDR_W-1:0]      src_addr,
    input  logic [ADDR_W-1:0]      dst_addr,
    input  logic [DATA_W-1:0]      acc_input,
    output logic [DATA_W-1:0]      alu_1st_in,
    output logic [DATA_W-1:0]      alu_2nd_in,
    inout  wire logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] src_val;
    logic              mode_wr;
    logic [DATA_W-1:0] mode_wdata;
    logic              bus_drive;

    assign src_val = regs[src_addr];

    // Mode-driven write enable and the value it would store.
    always_comb begin
        mode_wr    = 1'b0;
        mode_wdata = '0;
        if (enable && is_write_mode(mode)) begin
            mode_wr = 1'b1;
            unique case (mode)
                MODE_LOAD: mode_wdata = data;
                MODE_MOVE: mode_wdata = src_val;
                default:   mode_wdata = '0;
            endcase
        end
    end

    // Register array; the accumulator write is issued last so it wins on R0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (mode_wr) begin
                regs[dst_addr] <= mode_wdata;
            end
            if (acc_enable) begin
                regs[0] <= acc_input;
            end
        end
    end

    assign alu_1st_in = regs[0];
    assign alu_2nd_in = alu2in_enable ? src_val : '0;

    // Bus is released whenever this block is not actively reading, and during reset.
    assign bus_drive = !reset && enable && (mode == MODE_READ);
    assign data      = bus_drive ? src_val : {DATA_W{1'bz}};

endmodule

// File: tb/tb_general_purpose_register.sv
// Directed self-checking bench for general_purpose_register. The data bus has
// a weak pull-up, so a released bus reads as 16'hFFFF; high-Z checks are made
// while the selected source register holds a value other than 16'hFFFF.
module tb_general_purpose_register;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        alu2in_enable = 1'b0;
    logic        acc_enable = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [2:0]  src_addr = 3'd0;
    logic [2:0]  dst_addr = 3'd0;
    logic [15:0] acc_input = 16'h0000;
    logic [15:0] alu_1st_in;
    logic [15:0] alu_2nd_in;
    wire  [15:0] data;

    logic        tb_oe = 1'b0;
    logic [15:0] tb_drv = 16'h0000;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [15:0] PULLED = 16'hFFFF;

    assign data = tb_oe ? tb_drv : 16'hzzzz;

    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (data[i]);
    end

    always #5 clk = ~clk;

    general_purpose_register dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .alu2in_enable (alu2in_enable),
        .acc_enable    (acc_enable),
        .mode          (mode),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .acc_input     (acc_input),
        .alu_1st_in    (alu_1st_in),
        .alu_2nd_in    (alu_2nd_in),
        .data          (data)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic en, input logic [2:0] m, input logic [2:0] s, input logic [2:0] d);
        enable   = en;
        mode     = m;
        src_addr = s;
        dst_addr = d;
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [2:0] s, input logic [15:0] exp);
        op(1'b1, 3'b001, s, 3'd0);
        chk(tag, data, exp);
    endtask

    initial begin
        // Reset, with a READ requested: bus must stay released.
        op(1'b1, 3'b001, 3'd0, 3'd0);
        chk("data_z_in_reset", data, PULLED);
        tick();
        tick();
        reset = 1'b0;
        #1;

        for (int i = 0; i < 8; i++) begin
            read_chk($sformatf("reset_r%0d", i), 3'(i), 16'h0000);
        end
        alu2in_enable = 1'b1;
        op(1'b1, 3'b000, 3'd5, 3'd0);
        chk("reset_alu1", alu_1st_in, 16'h0000);
        chk("reset_alu2", alu_2nd_in, 16'h0000);
        alu2in_enable = 1'b0;

        // LOAD R3, blocked LOAD R1, LOAD R0.
        tb_oe = 1'b1;
        tb_drv = 16'h1234;
        op(1'b1, 3'b010, 3'd0, 3'd3);
        chk("load_bus_no_contention", data, 16'h1234);
        tick();
        tb_drv = 16'h4321;
        op(1'b0, 3'b010, 3'd0, 3'd1);
        tick();
        op(1'b1, 3'b010, 3'd0, 3'd0);
        tick();
        tb_oe = 1'b0;
        read_chk("load_r3", 3'd3, 16'h1234);
        read_chk("load_r2", 3'd2, 16'h0000);
        read_chk("load_disabled_r1", 3'd1, 16'h0000);
        read_chk("load_r0", 3'd0, 16'h4321);
        chk("load_alu1", alu_1st_in, 16'h4321);

        // ALU operand B gating.
        alu2in_enable = 1'b1;
        op(1'b1, 3'b000, 3'd3, 3'd0);
        chk("alu2_on", alu_2nd_in, 16'h1234);
        alu2in_enable = 1'b0;
        #1;
        chk("alu2_off", alu_2nd_in, 16'h0000);

        // MOVE, CLEAR, self-MOVE.
        op(1'b1, 3'b100, 3'd0, 3'd1);
        tick();
        read_chk("move_r1", 3'd1, 16'h4321);
        read_chk("move_src_kept", 3'd0, 16'h4321);
        op(1'b1, 3'b011, 3'd0, 3'd0);
        tick();
        read_chk("clear_r0", 3'd0, 16'h0000);
        chk("clear_alu1", alu_1st_in, 16'h0000);
        op(1'b1, 3'b100, 3'd3, 3'd3);
        tick();
        read_chk("self_move_r3", 3'd3, 16'h1234);

        // Accumulator write with enable low.
        op(1'b0, 3'b000, 3'd0, 3'd0);
        acc_enable = 1'b1;
        acc_input = 16'hFFFF;
        tick();
        acc_enable = 1'b0;
        read_chk("acc_r0", 3'd0, 16'hFFFF);
        chk("acc_alu1", alu_1st_in, 16'hFFFF);

        // Accumulator beats LOAD on R0.
        tb_oe = 1'b1;
        tb_drv = 16'h1111;
        acc_enable = 1'b1;
        acc_input = 16'hA5A5;
        op(1'b1, 3'b010, 3'd0, 3'd0);
        tick();
        tb_oe = 1'b0;
        acc_enable = 1'b0;
        read_chk("acc_wins_r0", 3'd0, 16'hA5A5);

        // Accumulator and LOAD to another register both land.
        tb_oe = 1'b1;
        tb_drv = 16'h5A5A;
        acc_enable = 1'b1;
        acc_input = 16'h0F0F;
        op(1'b1, 3'b010, 3'd0, 3'd5);
        tick();
        tb_oe = 1'b0;
        acc_enable = 1'b0;
        read_chk("dual_r0", 3'd0, 16'h0F0F);
        read_chk("dual_r5", 3'd5, 16'h5A5A);

        // Bus released for every non-READ mode and for enable low (src R5 = 5A5A).
        op(1'b1, 3'b000, 3'd5, 3'd6);
        chk("z_nop", data, PULLED);
        op(1'b1, 3'b011, 3'd5, 3'd6);
        chk("z_clear", data, PULLED);
        op(1'b1, 3'b100, 3'd5, 3'd6);
        chk("z_move", data, PULLED);
        op(1'b1, 3'b101, 3'd5, 3'd6);
        chk("z_m101", data, PULLED);
        op(1'b1, 3'b111, 3'd5, 3'd6);
        chk("z_m111", data, PULLED);
        op(1'b0, 3'b001, 3'd5, 3'd6);
        chk("z_disabled_read", data, PULLED);
        op(1'b1, 3'b000, 3'd5, 3'd6);
        tick();
        read_chk("nop_no_write_r6", 3'd6, 16'h0000);

        // Reset during an active LOAD.
        tb_oe = 1'b1;
        tb_drv = 16'h7777;
        op(1'b1, 3'b010, 3'd0, 3'd2);
        reset = 1'b1;
        tick();
        tb_oe = 1'b0;
        op(1'b1, 3'b001, 3'd5, 3'd0);
        chk("z_reset_read", data, PULLED);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            read_chk($sformatf("rst2_r%0d", i), 3'(i), 16'h0000);
        end
        chk("rst2_alu1", alu_1st_in, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
